// File: rtl/nrisc_int_ctrl_pkg.sv
// nrisc_int_ctrl_pkg: shared constants for the NRISC interrupt controller.
//   - default register window base and vector base
//   - register word offsets inside the 4-word window
//   - FSM state encoding (also visible to software through STATUS)
//   - lowest-index priority encoder
package nrisc_int_ctrl_pkg;

  localparam logic [15:0] INT_BASE_DFLT = 16'hFF00;
  localparam logic [7:0]  VEC_BASE_DFLT = 8'h00;

  localparam logic [1:0] INT_ENABLE = 2'd0;
  localparam logic [1:0] INT_PEND   = 2'd1;
  localparam logic [1:0] INT_EDGE   = 2'd2;
  localparam logic [1:0] INT_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Fixed priority: lowest set bit wins. Scans high to low so the last hit is the lowest.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) lowest_idx = 3'(i);
  endfunction

endpackage

// File: rtl/nrisc_int_ctrl_if.sv
// nrisc_int_ctrl_if: core-side bus of the interrupt controller.
//   D-Data port : DDATA_CORE_addr/in/write/load -> controller, int_rd_data/valid <- controller
//   Interrupt   : INTERRUPT_flag/ch <- controller, int_ack/int_done -> controller
// master = core side, slave = controller side.
interface nrisc_int_ctrl_if #(
  parameter int TAM     = 16,
  parameter int N_DData = 16
);
  logic [N_DData-1:0] DDATA_CORE_addr;
  logic [TAM-1:0]     DDATA_CORE_in;
  logic               DDATA_CORE_write;
  logic               DDATA_CORE_load;
  logic [TAM-1:0]     int_rd_data;
  logic               int_rd_valid;
  logic               INTERRUPT_flag;
  logic [7:0]         INTERRUPT_ch;
  logic               int_ack;
  logic               int_done;

  modport master (
    output DDATA_CORE_addr, DDATA_CORE_in, DDATA_CORE_write, DDATA_CORE_load,
    output int_ack, int_done,
    input  int_rd_data, int_rd_valid, INTERRUPT_flag, INTERRUPT_ch
  );

  modport slave (
    input  DDATA_CORE_addr, DDATA_CORE_in, DDATA_CORE_write, DDATA_CORE_load,
    input  int_ack, int_done,
    output int_rd_data, int_rd_valid, INTERRUPT_flag, INTERRUPT_ch
  );
endinterface

// File: rtl/nrisc_int_ctrl_sync.sv
// nrisc_int_sync: N-wide 2-flop synchroniser with rising-edge detect.
//   clk, rst   : clock, async active-low reset
//   i_async    : asynchronous request lines
//   o_lvl      : synchronised level (second flop)
//   o_rise     : one-cycle pulse when o_lvl goes 0 -> 1
module nrisc_int_sync #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_async,
  output logic [N-1:0] o_lvl,
  output logic [N-1:0] o_rise
);
  logic [N-1:0] r_s1, r_s2, r_s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s3 only remembers the previous synchronised level for edge detection.
  assign o_lvl  = r_s2;
  assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/nrisc_int_ctrl.sv
// nrisc_int_ctrl: 8-line fixed-priority interrupt controller for the NRISC core.
//   clk, rst : clock, async active-low reset
//   irq_in   : asynchronous request lines
//   bus      : slave side of nrisc_int_ctrl_if (register window on D-Data,
//              INTERRUPT_flag/ch to the core, int_ack/int_done from the core)
// Registers at INT_BASE+0..3: ENABLE, PENDING (W1C), EDGE_SEL, STATUS.
module nrisc_int_ctrl
  import nrisc_int_ctrl_pkg::*;
#(
  parameter int                 N_IRQ    = 8,
  parameter int                 TAM      = 16,
  parameter int                 N_DData  = 16,
  parameter logic [N_DData-1:0] INT_BASE = INT_BASE_DFLT,
  parameter logic [7:0]         VEC_BASE = VEC_BASE_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IRQ-1:0]  irq_in,
  nrisc_int_ctrl_if.slave   bus
);
  logic [N_IRQ-1:0]   w_lvl, w_rise, w_pend_nxt, w_elig, w_wdat;
  logic [N_IRQ-1:0]   r_en, r_pend, r_edge;
  logic [N_DData-1:0] w_off;
  logic [1:0]         w_sel;
  logic               w_hit, w_wr, w_rd, w_ack;
  logic [TAM-1:0]     w_rdat, r_rd_data;
  logic               r_rd_valid;
  state_t             r_st, w_st_nxt;
  logic [2:0]         r_idx, w_idx_nxt;

  nrisc_int_sync #(.N(N_IRQ)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (irq_in),
    .o_lvl   (w_lvl),
    .o_rise  (w_rise)
  );

  // Unsigned offset from the base: anything below INT_BASE wraps high and misses.
  assign w_off  = bus.DDATA_CORE_addr - INT_BASE;
  assign w_hit  = (w_off < N_DData'(4));
  assign w_sel  = w_off[1:0];
  assign w_wr   = bus.DDATA_CORE_write & w_hit;
  assign w_rd   = bus.DDATA_CORE_load  & w_hit;
  assign w_wdat = bus.DDATA_CORE_in[N_IRQ-1:0];
  assign w_elig = r_pend & r_en;
  assign w_ack  = bus.int_ack && (r_st == ST_ASSERT);

  if (TAM > N_IRQ) begin : g_wunused
    logic w_unused;
    assign w_unused = ^bus.DDATA_CORE_in[TAM-1:N_IRQ];
  end

  // Edge mode: a new rise beats any clear in the same cycle. Level mode follows the line.
  for (genvar i = 0; i < N_IRQ; i++) begin : g_pend
    logic w_clr;
    assign w_clr = (w_wr && (w_sel == INT_PEND) && w_wdat[i]) ||
                   (w_ack && (r_idx == 3'(i)));
    assign w_pend_nxt[i] = r_edge[i] ? (w_rise[i] | (r_pend[i] & ~w_clr)) : w_lvl[i];
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_idx_nxt = r_idx;
    unique case (r_st)
      ST_IDLE:    if (|w_elig) begin
                    w_st_nxt  = ST_ASSERT;
                    w_idx_nxt = lowest_idx(8'(w_elig));
                  end
      ST_ASSERT:  if (bus.int_ack)  w_st_nxt = ST_SERVICE;
      ST_SERVICE: if (bus.int_done) w_st_nxt = ST_IDLE;
      default:    w_st_nxt = ST_IDLE;
    endcase
  end

  // Read mux sees the current (pre-store) register values.
  always_comb begin
    w_rdat = '0;
    case (w_sel)
      INT_ENABLE: w_rdat[N_IRQ-1:0] = r_en;
      INT_PEND:   w_rdat[N_IRQ-1:0] = r_pend;
      INT_EDGE:   w_rdat[N_IRQ-1:0] = r_edge;
      INT_STATUS: w_rdat[9:0]       = {r_st, 5'b0, r_idx};
      default:    w_rdat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en       <= '0;
      r_pend     <= '0;
      r_edge     <= '0;
      r_st       <= ST_IDLE;
      r_idx      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_st       <= w_st_nxt;
      r_idx      <= w_idx_nxt;
      if (w_wr && (w_sel == INT_ENABLE)) r_en   <= w_wdat;
      if (w_wr && (w_sel == INT_EDGE))   r_edge <= w_wdat;
      r_rd_valid <= w_rd;
      r_rd_data  <= w_rd ? w_rdat : '0;
    end
  end

  // Flag is purely a function of state, so it stays stable for all of ASSERT.
  assign bus.INTERRUPT_flag = (r_st == ST_ASSERT);
  assign bus.INTERRUPT_ch   = VEC_BASE + {5'b0, r_idx};
  assign bus.int_rd_data    = r_rd_data;
  assign bus.int_rd_valid   = r_rd_valid;
endmodule

// File: tb/tb_nrisc_int_ctrl.sv
// tb_nrisc_int_ctrl: directed test-plan scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the controller.
module tb_nrisc_int_ctrl;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [7:0]  VEC  = 8'h20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq = 8'h00;
  int         n_chk = 0;
  int         n_err = 0;

  nrisc_int_ctrl_if #(.TAM(16), .N_DData(16)) bus ();

  nrisc_int_ctrl #(
    .N_IRQ(8), .TAM(16), .N_DData(16), .INT_BASE(BASE), .VEC_BASE(VEC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: registers, the last three sampled irq vectors
  // (s0 newest), controller mode 0=idle 1=asserting 2=in service.
  logic [7:0]  m_en, m_pend, m_edge, m_s0, m_s1, m_s2;
  int          m_st;
  logic [2:0]  m_idx;
  bit          m_rdv;
  logic [15:0] m_rdd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_edge = 0; m_s0 = 0; m_s1 = 0; m_s2 = 0;
    m_st = 0; m_idx = 0; m_rdv = 0; m_rdd = 0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic [15:0] off;
    bit          hit, ackf;
    logic [7:0]  rise, np, wclr;
    @(posedge clk);
    off   = bus.DDATA_CORE_addr - BASE;
    hit   = (off < 16'd4);
    m_rdv = bus.DDATA_CORE_load && hit;
    if (m_rdv)
      case (off[1:0])
        2'd0: m_rdd = {8'h00, m_en};
        2'd1: m_rdd = {8'h00, m_pend};
        2'd2: m_rdd = {8'h00, m_edge};
        default: m_rdd = {6'b0, m_st[1:0], 5'b0, m_idx};
      endcase
    rise = m_s1 & ~m_s2;
    wclr = (bus.DDATA_CORE_write && hit && off == 16'd1) ? bus.DDATA_CORE_in[7:0] : 8'h00;
    ackf = bus.int_ack && m_st == 1;
    for (int i = 0; i < 8; i++)
      np[i] = m_edge[i] ? (rise[i] || (m_pend[i] && !wclr[i] && !(ackf && m_idx == 3'(i))))
                        : m_s1[i];
    case (m_st)
      0: if ((m_pend & m_en) != 8'h00) begin
           m_st = 1;
           for (int i = 7; i >= 0; i--) if (m_pend[i] && m_en[i]) m_idx = 3'(i);
         end
      1: if (bus.int_ack)  m_st = 2;
      default: if (bus.int_done) m_st = 0;
    endcase
    m_pend = np;
    if (bus.DDATA_CORE_write && hit && off == 16'd0) m_en   = bus.DDATA_CORE_in[7:0];
    if (bus.DDATA_CORE_write && hit && off == 16'd2) m_edge = bus.DDATA_CORE_in[7:0];
    m_s2 = m_s1; m_s1 = m_s0; m_s0 = irq;
    #1;
    chk("flag", bus.INTERRUPT_flag, 32'(m_st == 1));
    chk("ch", bus.INTERRUPT_ch, 32'(8'(VEC + 8'(m_idx))));
    chk("rd_valid", bus.int_rd_valid, 32'(m_rdv));
    if (m_rdv) chk("rd_data", bus.int_rd_data, 32'(m_rdd));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    bus.DDATA_CORE_addr = BASE + 16'(off);
    bus.DDATA_CORE_in = {8'h00, d};
    bus.DDATA_CORE_write = 1'b1;
    step();
    bus.DDATA_CORE_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [15:0] v);
    bus.DDATA_CORE_addr = BASE + 16'(off);
    bus.DDATA_CORE_load = 1'b1;
    step();
    bus.DDATA_CORE_load = 1'b0;
    v = bus.int_rd_data;
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    bus.int_done = 1'b1; step(); bus.int_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    bus.DDATA_CORE_addr = 16'h0000; bus.DDATA_CORE_in = 16'h0000;
    bus.DDATA_CORE_write = 1'b0; bus.DDATA_CORE_load = 1'b0;
    bus.int_ack = 1'b0; bus.int_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_flag", bus.INTERRUPT_flag, 0);
    chk("rst_ch", bus.INTERRUPT_ch, 32'(VEC));
    chk("rst_rdv", bus.int_rd_valid, 0);
    chk("rst_rdd", bus.int_rd_data, 0);
    for (int r = 0; r < 4; r++) begin rd(2'(r), v); chk("rst_reg", v, 0); end

    // Edge request on line 0.
    wr(0, 8'h01); wr(2, 8'h01);
    irq[0] = 1'b1; step(); irq[0] = 1'b0; step(); step();
    chk("edge_k2_flag", bus.INTERRUPT_flag, 0);
    step();
    chk("edge_k3_flag", bus.INTERRUPT_flag, 1);
    chk("edge_ch", bus.INTERRUPT_ch, 32'(VEC));
    pulse_ack();
    chk("ack_flag", bus.INTERRUPT_flag, 0);
    rd(1, v); chk("ack_pend", v, 0);
    rd(3, v); chk("status_state", v[9:8], 2);
    pulse_done();

    // Priority: lines 5 and 2 together.
    wr(0, 8'hFF); wr(2, 8'hFF);
    irq = 8'h24; step(); irq = 8'h00; run(3);
    chk("prio_flag", bus.INTERRUPT_flag, 1);
    chk("prio_ch2", bus.INTERRUPT_ch, 32'(VEC + 8'd2));
    pulse_ack(); pulse_done(); step();
    chk("prio_flag2", bus.INTERRUPT_flag, 1);
    chk("prio_ch5", bus.INTERRUPT_ch, 32'(VEC + 8'd5));
    pulse_ack(); pulse_done();

    // Masking, then no nesting while in service.
    wr(0, 8'h00);
    irq[3] = 1'b1; step(); irq[3] = 1'b0; run(3);
    chk("mask_flag", bus.INTERRUPT_flag, 0);
    rd(1, v); chk("mask_pend", v, 16'h08);
    wr(0, 8'h01);
    irq[0] = 1'b1; step(); irq[0] = 1'b0; run(3);
    chk("svc_entry_ch", bus.INTERRUPT_ch, 32'(VEC));
    pulse_ack();
    wr(0, 8'h08); run(3);
    chk("nonest_flag", bus.INTERRUPT_flag, 0);
    pulse_done();
    chk("done_edge_flag", bus.INTERRUPT_flag, 0);
    step();
    chk("after_done_flag", bus.INTERRUPT_flag, 1);
    chk("after_done_ch", bus.INTERRUPT_ch, 32'(VEC + 8'd3));
    pulse_ack(); pulse_done();

    // Level mode on line 1.
    wr(2, 8'h00); wr(0, 8'h02);
    irq[1] = 1'b1; run(4);
    chk("lvl_ch", bus.INTERRUPT_ch, 32'(VEC + 8'd1));
    pulse_ack(); pulse_done(); step();
    chk("lvl_rereq", bus.INTERRUPT_flag, 1);
    pulse_ack();
    irq[1] = 1'b0; step(); step();
    rd(1, v); chk("lvl_pend_k2", v, 16'h02);
    rd(1, v); chk("lvl_pend_k3", v, 16'h00);
    pulse_done(); run(2);
    chk("lvl_idle", bus.INTERRUPT_flag, 0);

    // Clear race: W1C in the cycle the bit-4 edge is detected.
    wr(2, 8'hFF); wr(0, 8'h00);
    irq[4] = 1'b1; step(); irq[4] = 1'b0; step();
    wr(1, 8'h10);
    rd(1, v); chk("clr_race", v, 16'h10);
    wr(1, 8'h10);
    rd(1, v); chk("clr_plain", v, 16'h00);

    // Ack race: new edge on the latched channel in the ack cycle.
    wr(0, 8'h40);
    irq[6] = 1'b1; step(); irq[6] = 1'b0; run(3);
    chk("ackrace_ch", bus.INTERRUPT_ch, 32'(VEC + 8'd6));
    irq[6] = 1'b1; step(); irq[6] = 1'b0; step();
    pulse_ack();
    rd(1, v); chk("ack_race_pend", v, 16'h40);
    pulse_done(); step();
    chk("ack_race_rereq", bus.INTERRUPT_flag, 1);
    pulse_ack(); pulse_done();

    // Store and load to the same register in one cycle.
    bus.DDATA_CORE_addr = BASE; bus.DDATA_CORE_in = 16'h0055;
    bus.DDATA_CORE_write = 1'b1; bus.DDATA_CORE_load = 1'b1;
    step();
    bus.DDATA_CORE_write = 1'b0; bus.DDATA_CORE_load = 1'b0;
    chk("wr_rd_old", bus.int_rd_data, 16'h40);
    rd(0, v); chk("wr_rd_new", v, 16'h55);

    // Out-of-window accesses.
    foreach (v[i]) begin end
    for (int k = 0; k < 2; k++) begin
      bus.DDATA_CORE_addr = (k == 0) ? BASE + 16'd4 : BASE - 16'd1;
      bus.DDATA_CORE_in = 16'h00FF;
      bus.DDATA_CORE_write = 1'b1; bus.DDATA_CORE_load = 1'b1;
      step();
      bus.DDATA_CORE_write = 1'b0; bus.DDATA_CORE_load = 1'b0;
      chk("oow_rdv", bus.int_rd_valid, 0);
    end
    rd(0, v); chk("oow_en", v, 16'h55);
    wr(0, 8'h00);

    // Asynchronous reset while asserting.
    wr(0, 8'h80);
    irq[7] = 1'b1; step(); irq[7] = 1'b0; run(3);
    chk("pre_rst_ch", bus.INTERRUPT_ch, 32'(VEC + 8'd7));
    #3 rst = 1'b0;
    #1;
    chk("async_rst_flag", bus.INTERRUPT_flag, 0);
    chk("async_rst_ch", bus.INTERRUPT_ch, 32'(VEC));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int r = 0; r < 4; r++) begin rd(2'(r), v); chk("post_rst_reg", v, 0); end

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      int sel;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) irq[b] = ~irq[b];
      bus.int_ack  = (m_st == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      bus.int_done = (m_st == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 5);
      bus.DDATA_CORE_addr = (sel < 4) ? BASE + 16'(sel) : (sel == 4) ? BASE + 16'd4 : BASE - 16'd1;
      bus.DDATA_CORE_in = 16'($urandom);
      bus.DDATA_CORE_write = ($urandom_range(0, 9) == 0);
      bus.DDATA_CORE_load  = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.DDATA_CORE_write = 1'b0; bus.DDATA_CORE_load = 1'b0;
    bus.int_ack = 1'b0; bus.int_done = 1'b0;
    irq = 8'h00;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
